// File: rtl/array_nibble_loader.sv
// Collects a row-major stream of W-bit elements into a packed NI x NJ frame.
// A frame is held on B until downstream takes it. Broken frame-sync reports a one-cycle sync_err pulse.
module array_nibble_loader #(
    parameter int W  = 4,
    parameter int NI = 2,
    parameter int NJ = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  logic [W-1:0]                    in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NI-1:0][NJ-1:0][W-1:0]    B,
    output logic                            sync_err
);

    localparam int N  = NI * NJ;
    localparam int EW = (N > 1) ? $clog2(N) : 1;
    localparam logic [EW-1:0] LAST_E      = EW'(N - 1);
    localparam logic [EW-1:0] E_AFTER_HDR = (N > 1) ? EW'(1) : '0;

    typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

    state_t          state, state_next;
    logic [EW-1:0]   e, e_next;
    logic [EW-1:0]   wr_idx;
    logic            wr_en;
    logic            err_next;
    logic            xfer;
    logic [N*W-1:0]  frame;

    assign in_ready  = (state != FULL) || out_ready;
    assign out_valid = (state == FULL);
    assign xfer      = in_valid && in_ready;
    assign B         = frame;

    // Element [i][j] lives at flat slot i*NJ+j, so e addresses the frame directly.
    always_comb begin
        state_next = state;
        e_next     = e;
        wr_en      = 1'b0;
        wr_idx     = e;
        err_next   = 1'b0;
        case (state)
            EMPTY: begin
                if (xfer) begin
                    if (in_first) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        e_next     = E_AFTER_HDR;
                        state_next = (N == 1) ? FULL : FILL;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            FILL: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (in_first) begin
                        err_next   = 1'b1;
                        wr_idx     = '0;
                        e_next     = E_AFTER_HDR;
                        state_next = (N == 1) ? FULL : FILL;
                    end else if (e == LAST_E) begin
                        e_next     = '0;
                        state_next = FULL;
                    end else begin
                        e_next = e + EW'(1);
                    end
                end
            end
            FULL: begin
                // Handoff and the next frame's header may share one cycle.
                if (out_ready) begin
                    if (xfer && in_first) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        e_next     = E_AFTER_HDR;
                        state_next = (N == 1) ? FULL : FILL;
                    end else begin
                        err_next   = xfer;
                        e_next     = '0;
                        state_next = EMPTY;
                    end
                end
            end
            default: begin
                e_next     = '0;
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            e        <= '0;
            sync_err <= 1'b0;
            frame    <= '0;
        end else begin
            state    <= state_next;
            e        <= e_next;
            sync_err <= err_next;
            for (int k = 0; k < N; k++) begin
                if (wr_en && (wr_idx == EW'(k)))
                    frame[k*W +: W] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_array_nibble_loader.sv
// Self-checking bench for array_nibble_loader: a directed vector table and hand sequences, then random traffic.
// Every cycle is compared against a frame-level reference model.
module tb_array_nibble_loader;

    localparam int W  = 4;
    localparam int NI = 2;
    localparam int NJ = 3;
    localparam int NE = NI * NJ;

    logic                          clk;
    logic                          rst_n;
    logic                          in_valid;
    logic                          in_first;
    logic [W-1:0]                  in_data;
    logic                          in_ready;
    logic                          out_valid;
    logic                          out_ready;
    logic [NI-1:0][NJ-1:0][W-1:0]  B;
    logic                          sync_err;
    logic [NE*W-1:0]               b_flat;

    int checks = 0;
    int errors = 0;

    // Reference model: the elements gathered so far, how many, and whether a frame is on display.
    logic [W-1:0] m_frame [NE];
    int           m_count;
    bit           m_full;
    bit           m_err;

    typedef struct {
        logic         v;
        logic         f;
        logic [W-1:0] d;
        logic         o;
        logic         exp_ov;
        logic         exp_ir;
        logic         exp_se;
        logic [NE*W-1:0] exp_b;
    } vec_t;

    vec_t tbl [11];

    array_nibble_loader #(.W(W), .NI(NI), .NJ(NJ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .B         (B),
        .sync_err  (sync_err)
    );

    assign b_flat = B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [NE*W-1:0] modelB();
        logic [NE*W-1:0] b;
        for (int k = 0; k < NE; k++) b[k*W +: W] = m_frame[k];
        return b;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NE; k++) m_frame[k] = '0;
        m_count = 0;
        m_full  = 1'b0;
        m_err   = 1'b0;
    endtask

    // Called right after each rising edge with the inputs the DUT just sampled.
    task automatic modelStep();
        bit xfer;
        xfer = in_valid && (!m_full || out_ready);
        if (!rst_n) begin
            modelReset();
            return;
        end
        m_err = 1'b0;
        if (m_full && out_ready) m_full = 1'b0;
        if (xfer) begin
            if (in_first) begin
                m_err      = (m_count > 0);
                m_frame[0] = in_data;
                m_count    = 1;
            end else if (m_count == 0) begin
                m_err = 1'b1;
            end else begin
                m_frame[m_count] = in_data;
                m_count++;
                if (m_count == NE) begin
                    m_full  = 1'b1;
                    m_count = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic f,
                                 input logic [W-1:0] d, input logic o);
        rst_n     = r;
        in_valid  = v;
        in_first  = f;
        in_data   = d;
        out_ready = o;
        @(negedge clk);
    endtask

    task automatic checkOutput();
        checkVal("in_ready",  32'(in_ready),  32'(!m_full || out_ready));
        checkVal("out_valid", 32'(out_valid), 32'(m_full));
        checkVal("sync_err",  32'(sync_err),  32'(m_err));
        checkVal("B",         32'(b_flat),    32'(modelB()));
    endtask

    task automatic finishCycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic cycle(input logic r, input logic v, input logic f, input logic [W-1:0] d,
                         input logic o, output logic ov_s, output logic ir_s,
                         output logic se_s, output logic [NE*W-1:0] b_s);
        applyStimulus(r, v, f, d, o);
        checkOutput();
        ov_s = out_valid;
        ir_s = in_ready;
        se_s = sync_err;
        b_s  = b_flat;
        finishCycle();
    endtask

    initial begin
        logic            ov, ir, se;
        logic [NE*W-1:0] bs;
        int              ov_cnt;
        int              ov_at [2];
        int              ir_low;

        tbl[0]  = '{1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        tbl[1]  = '{1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000001};
        tbl[2]  = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000021};
        tbl[3]  = '{1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000321};
        tbl[4]  = '{1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 24'h004321};
        tbl[5]  = '{1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 24'h054321};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h654321};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h654321};
        tbl[8]  = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 24'h654321};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h654321};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h654321};

        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b0;
        modelReset();
        repeat (2) begin
            @(posedge clk);
            modelStep();
        end
        #1;

        // Directed vectors: one frame, its single-cycle handoff, then a stray element in EMPTY.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].o);
            checkOutput();
            checkVal($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            checkVal($sformatf("tbl%0d in_ready", i),  32'(in_ready),  32'(tbl[i].exp_ir));
            checkVal($sformatf("tbl%0d sync_err", i),  32'(sync_err),  32'(tbl[i].exp_se));
            checkVal($sformatf("tbl%0d B", i),         32'(b_flat),    32'(tbl[i].exp_b));
            finishCycle();
        end

        // Backpressure: full frame held while upstream keeps offering the next header.
        for (int i = 0; i < NE; i++)
            cycle(1'b1, 1'b1, (i == 0), W'(i + 1), 1'b0, ov, ir, se, bs);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 4'h7, 1'b0, ov, ir, se, bs);
            checkVal("stall in_ready", 32'(ir), 32'd0);
            checkVal("stall B", 32'(bs), 32'h654321);
        end
        cycle(1'b1, 1'b1, 1'b1, 4'h7, 1'b1, ov, ir, se, bs);
        checkVal("release in_ready", 32'(ir), 32'd1);
        for (int i = 0; i < NE - 1; i++)
            cycle(1'b1, 1'b1, 1'b0, W'(i + 8), 1'b1, ov, ir, se, bs);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, ov, ir, se, bs);
        checkVal("release frame", 32'(bs), 32'hCBA987);

        // Back-to-back frames with no idle cycles.
        ov_cnt = 0; ir_low = 0; ov_at[0] = -1; ov_at[1] = -1;
        for (int i = 0; i < 2 * NE + 2; i++) begin
            if (i < 2 * NE)
                cycle(1'b1, 1'b1, (i % NE == 0), W'(i + 1), 1'b1, ov, ir, se, bs);
            else
                cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, ov, ir, se, bs);
            if (ov) begin
                if (ov_cnt < 2) ov_at[ov_cnt] = i;
                ov_cnt++;
            end
            if (!ir) ir_low++;
        end
        checkVal("b2b frames", 32'(ov_cnt), 32'd2);
        checkVal("b2b spacing", 32'(ov_at[1] - ov_at[0]), 32'(NE));
        checkVal("b2b in_ready gaps", 32'(ir_low), 32'd0);

        // Header arrives on the 4th element: restart with that element as [0][0].
        cycle(1'b1, 1'b1, 1'b1, 4'h1, 1'b1, ov, ir, se, bs);
        cycle(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, ov, ir, se, bs);
        cycle(1'b1, 1'b1, 1'b0, 4'h3, 1'b1, ov, ir, se, bs);
        cycle(1'b1, 1'b1, 1'b1, 4'hD, 1'b1, ov, ir, se, bs);
        cycle(1'b1, 1'b1, 1'b0, 4'hE, 1'b1, ov, ir, se, bs);
        checkVal("restart sync_err", 32'(se), 32'd1);
        for (int i = 0; i < NE - 2; i++)
            cycle(1'b1, 1'b1, 1'b0, W'(i + 1), 1'b1, ov, ir, se, bs);
        checkVal("restart sync_err one cycle", 32'(se), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, ov, ir, se, bs);
        checkVal("restart out_valid", 32'(ov), 32'd1);
        checkVal("restart B", 32'(bs), 32'h4321ED);

        // Reset mid-frame abandons it.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, (i == 0), W'(i + 5), 1'b1, ov, ir, se, bs);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, ov, ir, se, bs);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov, ir, se, bs);
        checkVal("post-reset out_valid", 32'(ov), 32'd0);
        checkVal("post-reset in_ready", 32'(ir), 32'd1);
        checkVal("post-reset B", 32'(bs), 32'd0);
        for (int i = 0; i < NE; i++)
            cycle(1'b1, 1'b1, (i == 0), W'(i + 10), 1'b0, ov, ir, se, bs);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, ov, ir, se, bs);
        checkVal("post-reset frame valid", 32'(ov), 32'd1);
        checkVal("post-reset frame", 32'(bs), 32'hFEDCBA);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 6) == 0),
                  W'($urandom),
                  ($urandom_range(0, 2) != 0),
                  ov, ir, se, bs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
